// File: rtl/vedic_mult_seq.sv
// Digit-serial Vedic (Urdhva-Tiryagbhyam) multiplier: one radix-4 column per clock.
// Define VEDIC_SIGNED_EN for two's-complement operands/product; default build is unsigned.
module vedic_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int K   = WIDTH / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int CSW = $clog2(9 * K + 1);
  localparam int CW  = $clog2(2 * K);
  localparam logic [CW-1:0] LAST_COL = CW'(2 * K - 2);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_col;
  logic             r_neg;
  logic [PW-1:0]    r_out;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg;
  logic [CSW-1:0]   w_colsum;

`ifdef VEDIC_SIGNED_EN
  assign w_mag_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign w_mag_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign w_neg   = a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign w_mag_a = a;
  assign w_mag_b = b;
  assign w_neg   = 1'b0;
`endif

  // Sum of every 2x2 digit product lying on the current anti-diagonal.
  always_comb begin
    w_colsum = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (i + j == int'(r_col))
          w_colsum = w_colsum + CSW'({2'b00, r_a[2*i +: 2]} * {2'b00, r_b[2*j +: 2]});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CALC;
      S_CALC:  if (r_col == LAST_COL) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_col       <= '0;
      r_neg       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_neg <= w_neg;
            r_acc <= '0;
            r_col <= '0;
          end
        end
        S_CALC: begin
          r_acc <= r_acc + (PW'(w_colsum) << {r_col, 1'b0});
          r_col <= r_col + CW'(1);
        end
        S_FIX: begin
          // Negating zero yields zero, so no special case is needed.
          r_out       <= r_neg ? (~r_acc + PW'(1)) : r_acc;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq at WIDTH=8, randomized against an arithmetic model.
// Honours VEDIC_SIGNED_EN the same way as the design.
module tb_vedic_mult_seq;

  localparam int W  = 8;
  localparam int K  = W / 2;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] ex, ey;
`ifdef VEDIC_SIGNED_EN
    ex = {{W{x[W-1]}}, x};
    ey = {{W{y[W-1]}}, y};
`else
    ex = {{W{1'b0}}, x};
    ey = {{W{1'b0}}, y};
`endif
    return ex * ey;
  endfunction

  // One full transaction; hold>0 keeps out_ready low that many cycles after out_valid.
  task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] xb, input int hold);
    logic [PW-1:0] exp;
    int n;
    exp = model(xa, xb);
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1);
    a = xa; b = xb; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    checkOutput("busy_calc", busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 4 * K + 8);
    checkOutput("latency", n, 2 * K);
    checkOutput("product", out, exp);
    checkOutput("busy_done", busy, 0);
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_out", out, exp);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("out_kept", out, exp);
    checkOutput("back_idle", in_ready, 1);
  endtask

  task automatic backToBack(input int nOps);
    logic [PW-1:0] q[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    out_ready = 1'b1;
    while (got < nOps && cyc < nOps * (4 * K + 8)) begin
      @(negedge clk);
      if (in_ready) begin
        if (sent < nOps) begin
          a = W'($urandom); b = W'($urandom);
          q.push_back(model(a, b));
          in_valid = 1'b1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) checkOutput("b2b_spurious", out, 0);
        else               checkOutput("b2b_product", out, q.pop_front());
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b_count", got, nOps);
    checkOutput("b2b_leftover", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out", out, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'hFD, 8'h05, 0);
`ifdef VEDIC_SIGNED_EN
    checkOutput("neg15", out, 16'hFFF1);
    applyStimulus(8'h80, 8'h80, 0);
    checkOutput("min_sq", out, 16'h4000);
    applyStimulus(8'h7F, 8'hFF, 0);
    checkOutput("m127", out, 16'hFF81);
`else
    checkOutput("fd_x_05", out, 16'h04F1);
    applyStimulus(8'hFF, 8'hFF, 0);
    checkOutput("max_sq", out, 16'hFE01);
`endif
    applyStimulus(8'h00, 8'h80, 0);
    checkOutput("zero_op", out, 16'h0000);
    applyStimulus(8'h93, 8'hC5, 20);

    // Abort during CALC once column 3 is being accumulated.
    @(negedge clk);
    a = 8'hB7; b = 8'h6D; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out", out, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h02, 8'h03, 0);
    checkOutput("post_abort", out, 16'h0006);

    for (int i = 0; i < 300; i++)
      applyStimulus(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

    backToBack(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
